// File: rtl/rv_core_pkg.sv
//------------------------------------------------------------------------------
// Module      : rv_core_pkg
// Description : Shared types and constants for the RISC-V core front end.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_counter.sv
//------------------------------------------------------------------------------
// Module      : fetch_timeout_counter
// Description : Counts FETCH cycles without ack. start is held high while the
//               fetch is outstanding; the count is zero whenever it is low.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam logic [7:0] c_last_wait = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || !start || ack) begin
            r_count <= 8'd0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

    // An ack on the limit cycle masks expiry so the fetch completes cleanly.
    assign expired = start && !ack && (r_count == c_last_wait);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : instr_fetch_unit
// Description : PC, instruction-memory req/ack fetch and instruction register.
//               Optional fetch timeout enabled by macro FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fetch_err
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_instr_pc;
    logic         r_fetch_err;

    logic [31:0]  w_next_pc;
    logic         w_fetching;
    logic         w_timeout;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range_check
        $error("instr_fetch_unit: TIMEOUT_CYCLES out of range 1..255");
    end

    assign w_fetching = (r_state == FETCH);
    assign w_next_pc  = redirect ? redirect_target : (r_pc + 32'd4);

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .start   (w_fetching),
        .ack     (imem_ack),
        .expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= RV_NOP;
            r_instr_pc  <= RESET_PC;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_pc;
                        r_state    <= HOLD;
                    end else if (w_timeout) begin
                        r_fetch_err <= 1'b1;
                        r_state     <= TRAP;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        // A misaligned next PC traps without disturbing pc.
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= TRAP;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= FETCH;
                        end
                    end
                end
                TRAP: begin
                    r_state <= TRAP;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = w_fetching;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_err   = r_fetch_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fetch_err;

    int n_asserts = 0;
    int n_fail    = 0;

    instr_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .fetch_err       (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        cyc(); cyc();

        // Reset state
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_instr", instr,                c_nop);
        check("rst_ipc",   instr_pc,             32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_err",   {31'd0, fetch_err},   32'd0);

        // First fetch, zero-wait memory; ack during IDLE must be ignored
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        cyc();
        check("c1_req",   {31'd0, imem_req},    32'd1);
        check("c1_addr",  imem_addr,            32'h0);
        check("c1_valid", {31'd0, instr_valid}, 32'd0);
        check("c1_instr", instr,                c_nop);
        cyc();
        check("c2_instr", instr,                32'h0050_0093);
        check("c2_ipc",   instr_pc,             32'h0);
        check("c2_valid", {31'd0, instr_valid}, 32'd1);
        check("c2_req",   {31'd0, imem_req},    32'd0);

        // Sequential flow with 3 wait cycles per fetch
        imem_ack = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("w4_addr",  imem_addr,            32'h4);
            check("w4_req",   {31'd0, imem_req},    32'd1);
            check("w4_valid", {31'd0, instr_valid}, 32'd0);
            if (i == 3) begin imem_ack = 1'b1; imem_rdata = 32'h00A0_0113; end
        end
        cyc();
        check("s4_instr", instr,                32'h00A0_0113);
        check("s4_ipc",   instr_pc,             32'h4);
        check("s4_valid", {31'd0, instr_valid}, 32'd1);
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("w8_addr", imem_addr,         32'h8);
            check("w8_req",  {31'd0, imem_req}, 32'd1);
            if (i == 3) begin imem_ack = 1'b1; imem_rdata = 32'h0020_8193; end
        end
        cyc();
        check("s8_instr", instr,    32'h0020_8193);
        check("s8_ipc",   instr_pc, 32'h8);

        // Redirect from pc=8 to 0x100
        imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_0100;
        cyc();
        check("rd_addr", imem_addr,         32'h100);
        check("rd_req",  {31'd0, imem_req}, 32'd1);
        // Redirect outside HOLD is ignored
        redirect_target = 32'h0000_0200; imem_ack = 1'b1; imem_rdata = 32'h0000_0463;
        cyc();
        check("rd_ipc",   instr_pc,             32'h100);
        check("rd_valid", {31'd0, instr_valid}, 32'd1);
        imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        cyc();
        check("stall_valid", {31'd0, instr_valid}, 32'd1);
        check("stall_instr", instr,                32'h0000_0463);
        check("stall_req",   {31'd0, imem_req},    32'd0);

        // Misaligned target traps
        instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0102;
        cyc();
        check("mis_err",   {31'd0, fetch_err},   32'd1);
        check("mis_req",   {31'd0, imem_req},    32'd0);
        check("mis_valid", {31'd0, instr_valid}, 32'd0);
        check("mis_pc",    imem_addr,            32'h100);
        instr_ready = 1'b0; redirect = 1'b0; imem_ack = 1'b1;
        cyc();
        check("trap_err", {31'd0, fetch_err}, 32'd1);
        check("trap_req", {31'd0, imem_req},  32'd0);
        rst = 1'b1; imem_ack = 1'b0;
        cyc();
        check("clr_err",  {31'd0, fetch_err}, 32'd0);
        check("clr_addr", imem_addr,          32'h0);

        // PC wraps from 0xFFFFFFFC to 0 without error
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0010_0073;
        cyc(); cyc();
        check("wr_valid", {31'd0, instr_valid}, 32'd1);
        imem_ack = 1'b0; instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        cyc();
        check("wr_addr_hi", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_006F;
        cyc();
        check("wr_ipc", instr_pc, 32'hFFFF_FFFC);
        imem_ack = 1'b0;
        cyc();
        check("wr_addr0", imem_addr,          32'h0);
        check("wr_req",   {31'd0, imem_req},  32'd1);
        check("wr_err",   {31'd0, fetch_err}, 32'd0);

        // Reset mid-fetch together with ack
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_0040;
        cyc();
        check("mf_addr", imem_addr, 32'h40);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        redirect = 1'b0; instr_ready = 1'b0;
        cyc();
        check("mf_instr", instr,                c_nop);
        check("mf_valid", {31'd0, instr_valid}, 32'd0);
        check("mf_pc",    imem_addr,            32'h0);
        check("mf_ipc",   instr_pc,             32'h0);
        check("mf_req",   {31'd0, imem_req},    32'd0);
        rst = 1'b0; imem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // Ack withheld: error after 4 FETCH cycles
        cyc(); cyc(); cyc(); cyc();
        check("to_err_pre", {31'd0, fetch_err}, 32'd0);
        check("to_req_pre", {31'd0, imem_req},  32'd1);
        cyc();
        check("to_err", {31'd0, fetch_err}, 32'd1);
        check("to_req", {31'd0, imem_req},  32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        // Ack on the 4th FETCH cycle wins
        cyc(); cyc(); cyc(); cyc();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        cyc();
        check("to_ack_err",   {31'd0, fetch_err},   32'd0);
        check("to_ack_valid", {31'd0, instr_valid}, 32'd1);
        check("to_ack_instr", instr,                32'h0000_0033);
        imem_ack = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage for the single-cycle RISC-V core.
- Holds the program counter and requests 32-bit instruction words from instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register that directly drives the immediate extender's `DATA` input and the decoder.
- Advances the PC by 4, or redirects to a branch/jump target, when the execute side retires the held instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `TIMEOUT_CYCLES`, 255, maximum wait for `imem_ack` in FETCH. Used only with `FETCH_TIMEOUT_EN`; range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word address; equals `pc`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction, feeds extender/decoder.
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  `instr` is valid for execute.
- `instr_ready`  in  1  execute retires `instr` this cycle.
- `redirect`  in  1  retiring instruction is a taken branch or jump.
- `redirect_target`  in  32  next PC on redirect, computed from the extended B/J/I immediate.
- `fetch_err`  out  1  sticky error: misaligned target, or timeout.

## Operation
States: IDLE, FETCH, HOLD, TRAP.
- **IDLE:** entered on reset. Moves to FETCH on the next clock edge with `rst` low.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_pc`<=`pc`, state moves to HOLD.
- **HOLD:**
  - `instr_valid`=1; `instr` and `instr_pc` are frozen.
  - On `instr_ready`, next PC = `redirect ? redirect_target : pc+4`, and state moves to FETCH.
  - If the selected next PC has bits [1:0] != 0: `fetch_err`<=1, state moves to TRAP, and `pc` is not updated.
- **TRAP:** `imem_req`=0, `instr_valid`=0. The only exit is `rst`.

Rules:
- `redirect` and `redirect_target` are sampled only when `instr_valid && instr_ready`; otherwise they are ignored.
- `imem_ack` outside FETCH is ignored. `imem_rdata` is don't-care when `imem_ack` is 0.
- `pc+4` wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). This is not an error.
- `instr_ready` without `instr_valid` has no effect.
- `rst` has priority over every other event, including an `imem_ack` or `instr_ready` arriving in the same cycle.
- Reset in the middle of a fetch abandons the outstanding request. The memory must tolerate a dropped req.

Reset values:
- state=IDLE, `pc`=`RESET_PC`
- `instr`=32'h0000_0013 (NOP), `instr_pc`=`RESET_PC`
- `instr_valid`=0, `imem_req`=0, `fetch_err`=0

## Timing
- `imem_req`, `imem_addr` and `instr_valid` are decoded from the registered state and `pc` only. They have no combinational path from any input.
- `imem_ack` may arrive in the same cycle `imem_req` rises (zero-wait memory).
- First request is issued in cycle 1 after reset is released: edge 0 moves IDLE->FETCH.
- With zero-wait memory and `instr_ready` held high, one instruction retires every 2 cycles.
- Each extra memory wait cycle or `instr_ready` stall adds 1 cycle.
- `instr` changes only on the edge that leaves FETCH. The extender output is therefore stable for the whole of HOLD.

## Configuration
- **`FETCH_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to FETCH and increments on each FETCH cycle without `imem_ack`.
  - After `TIMEOUT_CYCLES` such cycles: `fetch_err`<=1, state moves to TRAP.
  - An ack in the same cycle the limit is reached wins: the fetch completes and there is no error.
- **Not defined:** FETCH waits for `imem_ack` indefinitely. `fetch_err` is caused only by misalignment, and no counter logic is present.

## Structure
- Shared package/header `rv_core_pkg`:
  - state encodings: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, TRAP=2'd3
  - `RV_NOP`=32'h0000_0013
  - default `RESET_PC`
- One sub-module, `fetch_timeout_counter`, instantiated only under `FETCH_TIMEOUT_EN`.
  - Inputs: `clk`, `rst`, `start`, `ack`.
  - Output: `expired`.

## Test plan
- **Reset and first fetch:** release `rst` with `RESET_PC`=0 and zero-wait memory returning 32'h00500093. Expect `imem_req`=1 at cycle 1, then `instr`=32'h00500093, `instr_pc`=0, `instr_valid`=1 at cycle 2.
- **Sequential flow:** hold `instr_ready`=1 and insert 3 ack wait cycles. Expect addresses 0, 4, 8 with `imem_addr` stable during the waits, and retirement every 5 cycles.
- **Redirect:** in HOLD at pc=8, assert `redirect` with target 32'h0000_0100. Expect the next `imem_addr`=32'h100, and no fetch from 12.
- **Misaligned target:** `redirect_target`=32'h0000_0102. Expect `fetch_err`=1, `imem_req`=0 thereafter, `pc` unchanged; `rst` clears the error.
- **Reset mid-fetch:** assert `rst` in a FETCH cycle together with `imem_ack`. Expect `instr`=NOP, `instr_valid`=0 and `pc`=`RESET_PC` after the edge.
- **`FETCH_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4:**
  - Withhold ack. Expect `fetch_err`=1 after 4 FETCH cycles.
  - Ack on the 4th cycle: expect no error.
